piece_sequencer: RTL and testbench

//   7-bag randomiser controller. Draws pseudo-random candidates from an internal LFSR and

---
 rtl/tetris_pkg.sv | 31 +++
 rtl/lfsr16.sv | 42 ++++
 rtl/piece_sequencer.sv | 176 +++++++++++++++++
 tb/tb_piece_sequencer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared types for the piece sequencer.
//   piece_t      : 3-bit piece code, legal values 0..6
//   NUM_PIECES   : pieces per bag
//   seq_state_t  : FILL (building a bag) / SERVE (handing pieces out)
//   lowest_clear : index of the lowest zero bit of a 7-bit flag vector
package tetris_pkg;

    typedef logic [2:0] piece_t;

    localparam int NUM_PIECES = 7;

    typedef enum logic {
        FILL  = 1'b0,
        SERVE = 1'b1
    } seq_state_t;

    // Priority encoder over ~flags; scanning downward leaves the lowest clear index.
    function automatic piece_t lowest_clear(input logic [6:0] flags);
        piece_t idx;
        idx = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (!flags[i]) begin
                idx = i[2:0];
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR (right shift, feedback mask 16'hB400).
//   clk, reset   : clock, asynchronous active-high reset (loads SEED_DEFAULT)
//   load         : load load_val instead of stepping this cycle
//   load_val     : new seed; zero is replaced by SEED_DEFAULT (zero is a lock-up state)
//   q            : current LFSR value
module lfsr16 #(
    parameter logic [15:0] SEED_DEFAULT = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [15:0] q
);

    logic [15:0] q_d;
    logic [15:0] q_q;

    // Next LFSR value: seed load or one Galois step.
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = (load_val == 16'h0000) ? SEED_DEFAULT : load_val;
        end else if (q_q[0]) begin
            q_d = (q_q >> 1) ^ 16'hB400;
        end else begin
            q_d = q_q >> 1;
        end
    end

    // LFSR state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= SEED_DEFAULT;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/piece_sequencer.sv
// 7-bag randomiser: fills a bag with a permutation of 0..6 by rejection sampling
// LFSR candidates, then serves the bag over a valid/ready handshake and refills.
//   clk, reset     : clock, asynchronous active-high reset
//   seed_load/seed : reseed the LFSR (seed 0 maps to SEED_DEFAULT)
//   flush          : drop the current bag and start a new fill
//   piece_ready    : consumer accepts the presented piece
//   piece_valid    : piece holds a served bag entry
//   piece          : current piece (registered)
//   bag_remaining  : entries not yet served in the current bag
//   filling        : high while building a bag
import tetris_pkg::*;

module piece_sequencer #(
    parameter logic [15:0] SEED_DEFAULT = 16'hACE1,
    parameter int          FILL_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        seed_load,
    input  logic [15:0] seed,
    input  logic        flush,
    input  logic        piece_ready,
    output logic        piece_valid,
    output logic [2:0]  piece,
    output logic [2:0]  bag_remaining,
    output logic        filling
);

    localparam int TIMER_W = $clog2(FILL_TIMEOUT) + 1;

    logic [15:0]        lfsr_val;
    logic               lfsr_unused;
    piece_t             cand;
    logic [7:0]         flags_ext;

    seq_state_t         state_d, state_q;
    logic [6:0]         flags_d, flags_q;
    logic [2:0]         wr_cnt_d, wr_cnt_q;
    logic [2:0]         rd_idx_d, rd_idx_q;
    logic [TIMER_W-1:0] timer_d, timer_q;
    piece_t             bag_d [0:NUM_PIECES-1];
    piece_t             bag_q [0:NUM_PIECES-1];
    piece_t             piece_d, piece_q;
    logic               piece_valid_d, piece_valid_q;
    logic [2:0]         bag_remaining_d, bag_remaining_q;
    logic               wr_en;
    piece_t             wr_val;

    lfsr16 #(.SEED_DEFAULT(SEED_DEFAULT)) u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .load     (seed_load),
        .load_val (seed),
        .q        (lfsr_val)
    );

    assign cand        = lfsr_val[2:0];
    assign lfsr_unused = ^lfsr_val[15:3];
    // Bit 7 set so that candidate 7 always reads as "already taken".
    assign flags_ext   = {1'b1, flags_q};

    // Next-state logic for fill, serve and flush.
    always_comb begin
        state_d         = state_q;
        flags_d         = flags_q;
        wr_cnt_d        = wr_cnt_q;
        rd_idx_d        = rd_idx_q;
        timer_d         = timer_q;
        bag_d           = bag_q;
        piece_d         = piece_q;
        piece_valid_d   = piece_valid_q;
        bag_remaining_d = bag_remaining_q;
        wr_en           = 1'b0;
        wr_val          = 3'd0;

        if (flush) begin
            // Flush wins over a simultaneous handshake: the presented piece is dropped.
            state_d         = FILL;
            flags_d         = 7'd0;
            wr_cnt_d        = 3'd0;
            rd_idx_d        = 3'd0;
            timer_d         = '0;
            piece_valid_d   = 1'b0;
            bag_remaining_d = 3'd0;
        end else begin
            case (state_q)
                FILL: begin
                    if (wr_cnt_q == 3'd6) begin
                        wr_en  = 1'b1;
                        wr_val = lowest_clear(flags_q);
                    end else if (timer_q >= TIMER_W'(FILL_TIMEOUT)) begin
                        wr_en  = 1'b1;
                        wr_val = lowest_clear(flags_q);
                    end else if (!flags_ext[cand]) begin
                        wr_en  = 1'b1;
                        wr_val = cand;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end

                    if (wr_en) begin
                        bag_d[wr_cnt_q] = wr_val;
                        flags_d[wr_val] = 1'b1;
                        wr_cnt_d        = wr_cnt_q + 3'd1;
                        if (wr_cnt_q == 3'd6) begin
                            // Last write completes the bag; bag[0] was written long ago.
                            state_d         = SERVE;
                            rd_idx_d        = 3'd0;
                            bag_remaining_d = 3'd7;
                            piece_d         = bag_q[0];
                            piece_valid_d   = 1'b1;
                            timer_d         = '0;
                        end else begin
                            state_d = FILL;
                        end
                    end else begin
                        wr_cnt_d = wr_cnt_q;
                    end
                end
                SERVE: begin
                    if (piece_valid_q && piece_ready) begin
                        if (rd_idx_q == 3'd6) begin
                            state_d         = FILL;
                            flags_d         = 7'd0;
                            wr_cnt_d        = 3'd0;
                            piece_valid_d   = 1'b0;
                            bag_remaining_d = 3'd0;
                        end else begin
                            rd_idx_d        = rd_idx_q + 3'd1;
                            bag_remaining_d = bag_remaining_q - 3'd1;
                            piece_d         = bag_q[rd_idx_q + 3'd1];
                        end
                    end else begin
                        piece_d = piece_q;
                    end
                end
                default: begin
                    state_d = FILL;
                end
            endcase
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= FILL;
            flags_q         <= 7'd0;
            wr_cnt_q        <= 3'd0;
            rd_idx_q        <= 3'd0;
            timer_q         <= '0;
            piece_q         <= 3'd0;
            piece_valid_q   <= 1'b0;
            bag_remaining_q <= 3'd0;
            for (int i = 0; i < NUM_PIECES; i++) begin
                bag_q[i] <= 3'd0;
            end
        end else begin
            state_q         <= state_d;
            flags_q         <= flags_d;
            wr_cnt_q        <= wr_cnt_d;
            rd_idx_q        <= rd_idx_d;
            timer_q         <= timer_d;
            piece_q         <= piece_d;
            piece_valid_q   <= piece_valid_d;
            bag_remaining_q <= bag_remaining_d;
            bag_q           <= bag_d;
        end
    end

    assign piece_valid   = piece_valid_q;
    assign piece         = piece_q;
    assign bag_remaining = bag_remaining_q;
    assign filling       = (state_q == FILL);

endmodule

// File: tb/tb_piece_sequencer.sv
// Scoreboard bench for piece_sequencer: a reference model predicts each bag and
// pushes the expected pieces; a monitor pops and compares on every served piece.
module tb_piece_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        seed_load = 1'b0;
    logic [15:0] seed = 16'h0000;
    logic        flush = 1'b0;
    logic        piece_ready = 1'b1;
    logic        piece_valid;
    logic [2:0]  piece;
    logic [2:0]  bag_remaining;
    logic        filling;

    piece_sequencer #(.SEED_DEFAULT(16'hACE1), .FILL_TIMEOUT(64)) dut (
        .clk           (clk),
        .reset         (reset),
        .seed_load     (seed_load),
        .seed          (seed),
        .flush         (flush),
        .piece_ready   (piece_ready),
        .piece_valid   (piece_valid),
        .piece         (piece),
        .bag_remaining (bag_remaining),
        .filling       (filling)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] p;
        logic [2:0] rem;
    } exp_t;

    exp_t       exp_q[$];
    logic [2:0] cap_q[$];
    logic [2:0] run_a [21];
    logic [2:0] run_b [21];
    int         n_checks = 0;
    int         n_pass = 0;
    bit         force_on = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic logic [2:0] first_free(input logic [7:0] f);
        logic [2:0] r;
        bit found;
        r = 3'd0;
        found = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (!found && !f[i]) begin
                r = 3'(i);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    // Reference model state
    logic [15:0] m_lfsr = 16'hACE1;
    bit          m_serve = 1'b0;
    logic [7:0]  m_flags = 8'h00;
    int          m_wr = 0;
    int          m_rd = 0;
    int          m_timer = 0;
    logic [2:0]  m_bag [7];
    logic [2:0]  m_cand;
    logic [2:0]  m_val;
    bit          m_hit;

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            m_lfsr = 16'hACE1; m_serve = 1'b0; m_flags = 8'h00;
            m_wr = 0; m_rd = 0; m_timer = 0;
            exp_q.delete();
        end else begin
            if (flush) begin
                m_serve = 1'b0; m_flags = 8'h00; m_wr = 0; m_rd = 0; m_timer = 0;
                exp_q.delete();
            end else if (!m_serve) begin
                m_cand = force_on ? 3'd7 : m_lfsr[2:0];
                m_hit = 1'b0;
                if (m_wr == 6 || m_timer >= 64) begin
                    m_hit = 1'b1;
                    m_val = first_free(m_flags);
                end else if (m_cand != 3'd7 && !m_flags[m_cand]) begin
                    m_hit = 1'b1;
                    m_val = m_cand;
                end else begin
                    m_timer++;
                end
                if (m_hit) begin
                    m_bag[m_wr] = m_val;
                    m_flags[m_val] = 1'b1;
                    m_wr++;
                    if (m_wr == 7) begin
                        for (int i = 0; i < 7; i++)
                            exp_q.push_back('{p: m_bag[i], rem: 3'(7 - i)});
                        m_serve = 1'b1; m_rd = 0; m_timer = 0;
                    end
                end
            end else if (piece_ready) begin
                m_rd++;
                if (m_rd == 7) begin
                    m_serve = 1'b0; m_flags = 8'h00; m_wr = 0;
                end
            end
            if (seed_load) m_lfsr = (seed == 16'h0000) ? 16'hACE1 : seed;
            else m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
        end
    end

    // Monitor: compare every presented piece against the scoreboard front.
    initial forever begin
        @(negedge clk);
        if (!reset && piece_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                check("piece", int'(piece), int'(exp_q[0].p));
                check("bag_remaining", int'(bag_remaining), int'(exp_q[0].rem));
                if (piece_ready && !flush) begin
                    void'(exp_q.pop_front());
                    cap_q.push_back(piece);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_fill(output int n);
        n = 0;
        while (filling && n < 200) begin
            cyc();
            n++;
        end
    endtask

    task automatic wait_caps(input string name, input int k);
        int b;
        b = 0;
        while (cap_q.size() < k && b < 400) begin
            cyc();
            b++;
        end
        check(name, int'(cap_q.size() >= k), 1);
    endtask

    task automatic check_perm(input string name, input int start);
        logic [7:0] m;
        m = 8'h00;
        for (int i = 0; i < 7; i++)
            if (start + i < cap_q.size()) m[cap_q[start + i]] = 1'b1;
        check(name, int'(m), 32'h7F);
    endtask

    task automatic run_seed(input logic [15:0] s);
        reset = 1'b1; cyc(); reset = 1'b0;
        piece_ready = 1'b1;
        cyc(); cyc(); cyc();
        seed = s; seed_load = 1'b1; cyc(); seed_load = 1'b0;
        cap_q.delete();
        wait_caps("t2_caps", 21);
    endtask

    initial begin
        int n;
        logic [2:0] p0;
        logic [2:0] r0;

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        check("rst_valid", int'(piece_valid), 0);
        check("rst_piece", int'(piece), 0);
        check("rst_rem", int'(bag_remaining), 0);
        check("rst_filling", int'(filling), 1);
        reset = 1'b0;

        // T1: default seed, ready=1
        cap_q.delete();
        wait_fill(n);
        check("t1_fill_latency_in_7_71", int'(n >= 7 && n <= 71), 1);
        for (int i = 0; i < 7; i++) begin
            check("t1_valid", int'(piece_valid), 1);
            check("t1_rem", int'(bag_remaining), 7 - i);
            cyc();
        end
        check("t1_end_valid", int'(piece_valid), 0);
        check("t1_end_rem", int'(bag_remaining), 0);
        check_perm("t1_perm", 0);

        // T2: seed 0 equals seed ACE1
        run_seed(16'h0000);
        for (int i = 0; i < 21; i++) run_a[i] = cap_q[i];
        run_seed(16'hACE1);
        for (int i = 0; i < 21; i++) run_b[i] = cap_q[i];
        for (int i = 0; i < 21; i++) check("t2_same_stream", int'(run_b[i]), int'(run_a[i]));
        for (int b = 0; b < 3; b++) check_perm("t2_perm", 7 * b);

        // T3: stall in SERVE
        flush = 1'b1; cyc(); flush = 1'b0;
        piece_ready = 1'b0;
        wait_fill(n);
        check("t3_valid", int'(piece_valid), 1);
        p0 = piece;
        r0 = bag_remaining;
        check("t3_rem_start", int'(r0), 7);
        for (int i = 0; i < 20; i++) begin
            cyc();
            check("t3_stall_piece", int'(piece), int'(p0));
            check("t3_stall_rem", int'(bag_remaining), int'(r0));
        end
        piece_ready = 1'b1; cyc(); piece_ready = 1'b0;
        check("t3_after_hs_rem", int'(bag_remaining), 6);
        check("t3_after_hs_valid", int'(piece_valid), 1);

        // T4: flush with handshake at bag_remaining=4
        piece_ready = 1'b1;
        n = 0;
        while (bag_remaining != 3'd4 && n < 20) begin cyc(); n++; end
        check("t4_reach_rem4", int'(bag_remaining), 4);
        flush = 1'b1; cyc(); flush = 1'b0;
        check("t4_valid", int'(piece_valid), 0);
        check("t4_rem", int'(bag_remaining), 0);
        check("t4_filling", int'(filling), 1);
        cap_q.delete();
        wait_caps("t4_caps", 7);
        check_perm("t4_perm", 0);

        // T5: candidates forced to 7 -> fallback fill
        force_on = 1'b1;
        force dut.lfsr_val = 16'h0007;
        flush = 1'b1; cyc(); flush = 1'b0;
        cap_q.delete();
        wait_fill(n);
        check("t5_fill_cycles", n, 71);
        wait_caps("t5_caps", 7);
        for (int i = 0; i < 7; i++) check("t5_fallback_order", int'(cap_q[i]), i);
        release dut.lfsr_val;
        force_on = 1'b0;
        reset = 1'b1; cyc(); reset = 1'b0;

        // T6: async reset mid-SERVE at bag_remaining=3
        piece_ready = 1'b1;
        n = 0;
        while (!(piece_valid && bag_remaining == 3'd3) && n < 200) begin cyc(); n++; end
        check("t6_reach_rem3", int'(bag_remaining), 3);
        reset = 1'b1;
        #1;
        check("t6_rst_valid", int'(piece_valid), 0);
        check("t6_rst_piece", int'(piece), 0);
        check("t6_rst_rem", int'(bag_remaining), 0);
        check("t6_rst_filling", int'(filling), 1);
        cyc();
        reset = 1'b0;
        cap_q.delete();
        wait_fill(n);
        check("t6_fill_latency_in_7_71", int'(n >= 7 && n <= 71), 1);
        wait_caps("t6_caps", 7);
        check_perm("t6_perm", 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
